// File: rtl/semaforo_pkg.sv
// Shared encodings for the traffic-light controller and its runtime monitor:
// lamp patterns, observed phase, fault codes and the monitor state enum.
package semaforo_pkg;

  typedef enum logic [1:0] {
    PH_NONE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    FC_PATTERN = 2'd0,
    FC_ORDER   = 2'd1,
    FC_SHORT   = 2'd2,
    FC_LONG    = 2'd3
  } fault_code_e;

  typedef enum logic [2:0] {
    MON_IDLE,
    MON_SYNC,
    MON_GREEN,
    MON_YELLOW,
    MON_RED,
    MON_FAULT
  } mon_state_e;

  // Lamp vectors are ordered {red, yellow, green}
  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // Non-one-hot patterns map to PH_NONE so callers can treat them as illegal
  function automatic phase_e lamp_to_phase(input logic [2:0] lamp);
    case (lamp)
      LAMP_GREEN:  lamp_to_phase = PH_GREEN;
      LAMP_YELLOW: lamp_to_phase = PH_YELLOW;
      LAMP_RED:    lamp_to_phase = PH_RED;
      default:     lamp_to_phase = PH_NONE;
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      PH_RED:    next_phase = PH_GREEN;
      default:   next_phase = PH_NONE;
    endcase
  endfunction

  function automatic phase_e state_to_phase(input mon_state_e st);
    case (st)
      MON_GREEN:  state_to_phase = PH_GREEN;
      MON_YELLOW: state_to_phase = PH_YELLOW;
      MON_RED:    state_to_phase = PH_RED;
      default:    state_to_phase = PH_NONE;
    endcase
  endfunction

  function automatic mon_state_e phase_to_state(input phase_e ph);
    case (ph)
      PH_GREEN:  phase_to_state = MON_GREEN;
      PH_YELLOW: phase_to_state = MON_YELLOW;
      PH_RED:    phase_to_state = MON_RED;
      default:   phase_to_state = MON_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Lamp/enable observation bus and fault/status reporting of the monitor.
// The master side is the controller (or bench); the monitor is the slave.
interface semaforo_monitor_if;

  logic        enable;
  logic        red;
  logic        yellow;
  logic        green;
  logic        clr_fault;
  logic        fault;
  logic [1:0]  fault_code;
  logic [1:0]  phase_out;
  logic [15:0] cycle_count;

  modport master (
    output enable, red, yellow, green, clr_fault,
    input  fault, fault_code, phase_out, cycle_count
  );

  modport slave (
    input  enable, red, yellow, green, clr_fault,
    output fault, fault_code, phase_out, cycle_count
  );

endinterface

// File: rtl/semaforo_dwell_timer.sv
// Saturating dwell counter with per-phase MIN/MAX comparison.
// over_max means one more sample of the same phase would exceed MAX.
module semaforo_dwell_timer
  import semaforo_pkg::*;
#(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 3,
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 8,
  parameter int CNT_W      = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   load_one,
  input  logic   incr,
  input  phase_e phase_sel,
  output logic   below_min,
  output logic   over_max
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] sel_min;
  logic [CNT_W-1:0] sel_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load_one) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (incr && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    sel_min = CNT_W'(GREEN_MIN);
    sel_max = CNT_W'(GREEN_MAX);
    case (phase_sel)
      PH_YELLOW: begin
        sel_min = CNT_W'(YELLOW_MIN);
        sel_max = CNT_W'(YELLOW_MAX);
      end
      PH_RED: begin
        sel_min = CNT_W'(RED_MIN);
        sel_max = CNT_W'(RED_MAX);
      end
      default: begin
        sel_min = CNT_W'(GREEN_MIN);
        sel_max = CNT_W'(GREEN_MAX);
      end
    endcase
  end

  assign below_min = (cnt_q < sel_min);
  assign over_max  = (cnt_q >= sel_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Safety watchdog for the traffic-light lamps: tracks the phase, flags the
// first encoding/order/dwell fault with a code and counts completed cycles.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 3,
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 8,
  parameter int CNT_W      = 8
) (
  input logic               clk,
  input logic               rst_n,
  semaforo_monitor_if.slave bus
);

  logic [2:0]  lamp_q, lamp_d;
  logic        en_q, en_d;
  mon_state_e  state_q, state_d;
  logic        fault_q, fault_d;
  fault_code_e fault_code_q, fault_code_d;
  phase_e      phase_q, phase_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic        first_q, first_d;

  phase_e      cur_phase;
  phase_e      lamp_phase;
  logic        tmr_clear, tmr_load, tmr_incr;
  logic        below_min, over_max;
  logic        detect;
  fault_code_e detect_code;

  always_comb begin
    lamp_d = {bus.red, bus.yellow, bus.green};
    en_d   = bus.enable;
  end

  semaforo_dwell_timer #(
    .GREEN_MIN  (GREEN_MIN),
    .GREEN_MAX  (GREEN_MAX),
    .YELLOW_MIN (YELLOW_MIN),
    .YELLOW_MAX (YELLOW_MAX),
    .RED_MIN    (RED_MIN),
    .RED_MAX    (RED_MAX),
    .CNT_W      (CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (tmr_clear),
    .load_one  (tmr_load),
    .incr      (tmr_incr),
    .phase_sel (cur_phase),
    .below_min (below_min),
    .over_max  (over_max)
  );

  always_comb begin
    cur_phase     = state_to_phase(state_q);
    lamp_phase    = lamp_to_phase(lamp_q);
    state_d       = state_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    cycle_count_d = cycle_count_q;
    first_d       = first_q;
    tmr_clear     = 1'b0;
    tmr_load      = 1'b0;
    tmr_incr      = 1'b0;
    detect        = 1'b0;
    detect_code   = FC_PATTERN;

    case (state_q)
      MON_IDLE: begin
        tmr_clear = 1'b1;
        if (en_q) begin
          state_d = MON_SYNC;
        end else if (lamp_q != LAMP_OFF) begin
          detect = 1'b1;
        end
      end

      // The first phase after sync may have been entered part-way through,
      // so its minimum dwell cannot be judged.
      MON_SYNC: begin
        tmr_clear = 1'b1;
        if (!en_q) begin
          state_d = MON_IDLE;
        end else if (lamp_q == LAMP_OFF) begin
          state_d = MON_SYNC;
        end else if (lamp_phase != PH_NONE) begin
          state_d   = phase_to_state(lamp_phase);
          tmr_clear = 1'b0;
          tmr_load  = 1'b1;
          first_d   = 1'b1;
        end else begin
          detect = 1'b1;
        end
      end

      MON_GREEN, MON_YELLOW, MON_RED: begin
        if (!en_q) begin
          state_d   = MON_IDLE;
          tmr_clear = 1'b1;
        end else if (lamp_phase == PH_NONE) begin
          detect = 1'b1;
        end else if (lamp_phase == cur_phase) begin
          if (over_max) begin
            detect      = 1'b1;
            detect_code = FC_LONG;
          end else begin
            tmr_incr = 1'b1;
          end
        end else if (lamp_phase == next_phase(cur_phase)) begin
          if (below_min && !first_q) begin
            detect      = 1'b1;
            detect_code = FC_SHORT;
          end else begin
            state_d  = phase_to_state(lamp_phase);
            tmr_load = 1'b1;
            first_d  = 1'b0;
            if (cur_phase == PH_RED) begin
              cycle_count_d = cycle_count_q + 16'd1;
            end
          end
        end else begin
          detect      = 1'b1;
          detect_code = FC_ORDER;
        end
      end

      MON_FAULT: begin
        tmr_clear = 1'b1;
        if (bus.clr_fault) begin
          state_d      = en_q ? MON_SYNC : MON_IDLE;
          fault_d      = 1'b0;
          fault_code_d = FC_PATTERN;
        end
      end

      default: begin
        state_d   = MON_IDLE;
        tmr_clear = 1'b1;
      end
    endcase

    // A clear arriving with a fresh fault wins; the fault is re-detected on
    // the next sample if the lamps still show it.
    if (detect) begin
      tmr_clear = 1'b1;
      tmr_load  = 1'b0;
      tmr_incr  = 1'b0;
      if (bus.clr_fault) begin
        state_d = en_q ? MON_SYNC : MON_IDLE;
      end else begin
        state_d      = MON_FAULT;
        fault_d      = 1'b1;
        fault_code_d = detect_code;
      end
    end
  end

  // The reported phase freezes at its last value while a fault is latched
  always_comb begin
    phase_d = state_to_phase(state_d);
    if (state_d == MON_FAULT) begin
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_q        <= LAMP_OFF;
      en_q          <= 1'b0;
      state_q       <= MON_IDLE;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_PATTERN;
      phase_q       <= PH_NONE;
      cycle_count_q <= 16'd0;
      first_q       <= 1'b0;
    end else begin
      lamp_q        <= lamp_d;
      en_q          <= en_d;
      state_q       <= state_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      phase_q       <= phase_d;
      cycle_count_q <= cycle_count_d;
      first_q       <= first_d;
    end
  end

  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.phase_out   = phase_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: a cycle model predicts each sample's
// outcome, which is queued at drive time and compared once the DUT has updated.
module tb_semaforo_monitor;

  localparam int GMIN = 4, GMAX = 8, YMIN = 2, YMAX = 3, RMIN = 4, RMAX = 8;
  localparam int ST_IDLE = 0, ST_GREEN = 1, ST_YELLOW = 2, ST_RED = 3;
  localparam int ST_SYNC = 4, ST_FAULT = 5;
  localparam logic [2:0] OFF = 3'b000, G = 3'b001, Y = 3'b010, R = 3'b100;

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic [1:0]  phase;
    logic [15:0] count;
  } expect_t;

  logic clk;
  logic rst_n;
  semaforo_monitor_if bus ();

  semaforo_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  expect_t sbQueue[$];

  int mState, mDwell, mFirst, mFault, mCode, mCount, mEn;
  logic [2:0] mLamp;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checkCount++;
    if (obs !== expVal) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, expVal);
    end
  endtask

  function automatic int lampPhase(input logic [2:0] l);
    case (l)
      G: return 1;
      Y: return 2;
      R: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int minOf(input int ph);
    return (ph == 1) ? GMIN : (ph == 2) ? YMIN : RMIN;
  endfunction

  function automatic int maxOf(input int ph);
    return (ph == 1) ? GMAX : (ph == 2) ? YMAX : RMAX;
  endfunction

  task automatic modelReset();
    mState = ST_IDLE; mDwell = 0; mFirst = 0; mFault = 0;
    mCode = 0; mCount = 0; mEn = 0; mLamp = OFF;
  endtask

  // One clock of the reference model: judge the previously registered sample
  task automatic modelStep(input logic clrIn, input logic [2:0] lampIn, input logic enIn);
    int lp;
    int f;
    f  = -1;
    lp = lampPhase(mLamp);
    case (mState)
      ST_IDLE: begin
        if (mEn != 0) mState = ST_SYNC;
        else if (mLamp != OFF) f = 0;
      end
      ST_SYNC: begin
        if (mEn == 0) mState = ST_IDLE;
        else if (mLamp == OFF) mState = ST_SYNC;
        else if (lp != 0) begin
          mState = lp; mDwell = 1; mFirst = 1;
        end else f = 0;
      end
      ST_GREEN, ST_YELLOW, ST_RED: begin
        if (mEn == 0) begin
          mState = ST_IDLE; mDwell = 0;
        end else if (lp == 0) f = 0;
        else if (lp == mState) begin
          if (mDwell >= maxOf(mState)) f = 3;
          else mDwell++;
        end else if (lp == (mState % 3) + 1) begin
          if (mFirst == 0 && mDwell < minOf(mState)) f = 2;
          else begin
            if (mState == ST_RED) mCount = (mCount + 1) & 16'hffff;
            mState = lp; mDwell = 1; mFirst = 0;
          end
        end else f = 1;
      end
      default: begin
        if (clrIn) begin
          mState = (mEn != 0) ? ST_SYNC : ST_IDLE;
          mFault = 0; mCode = 0;
        end
      end
    endcase
    if (f >= 0) begin
      if (clrIn) mState = (mEn != 0) ? ST_SYNC : ST_IDLE;
      else begin
        mState = ST_FAULT; mFault = 1; mCode = f;
      end
    end
    mLamp = lampIn;
    mEn   = enIn ? 1 : 0;
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] lamp, input logic clr, input int n);
    expect_t e;
    expect_t got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.enable    = en;
      bus.red       = lamp[2];
      bus.yellow    = lamp[1];
      bus.green     = lamp[0];
      bus.clr_fault = clr;
      modelStep(clr, lamp, en);
      e.fault = (mFault != 0);
      e.code  = 2'(mCode);
      e.phase = (mState >= ST_GREEN && mState <= ST_RED) ? 2'(mState) : 2'd0;
      e.count = 16'(mCount);
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
      got = sbQueue.pop_front();
      checkOutput("fault", 32'(bus.fault), 32'(got.fault));
      checkOutput("fault_code", 32'(bus.fault_code), 32'(got.code));
      checkOutput("cycle_count", 32'(bus.cycle_count), 32'(got.count));
      if (!got.fault) checkOutput("phase_out", 32'(bus.phase_out), 32'(got.phase));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_fault"}, 32'(bus.fault), 32'd0);
    checkOutput({tag, "_code"}, 32'(bus.fault_code), 32'd0);
    checkOutput({tag, "_phase"}, 32'(bus.phase_out), 32'd0);
    checkOutput({tag, "_count"}, 32'(bus.cycle_count), 32'd0);
  endtask

  task automatic lightCycle(input int gN, input int yN, input int rN);
    applyStimulus(1'b1, G, 1'b0, gN);
    applyStimulus(1'b1, Y, 1'b0, yN);
    applyStimulus(1'b1, R, 1'b0, rN);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.red = 1'b0; bus.yellow = 1'b0;
    bus.green = 1'b0;  bus.clr_fault = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Legal running sequence, three full cycles
    applyStimulus(1'b1, OFF, 1'b0, 2);
    repeat (3) lightCycle(4, 2, 4);

    // Green too short before yellow
    applyStimulus(1'b1, G, 1'b0, 3);
    applyStimulus(1'b1, Y, 1'b0, 2);

    // Clear, then green held past its maximum
    applyStimulus(1'b1, G, 1'b1, 1);
    applyStimulus(1'b1, G, 1'b0, 10);

    // Skip from green straight to red
    applyStimulus(1'b1, OFF, 1'b1, 1);
    applyStimulus(1'b1, G, 1'b0, 5);
    applyStimulus(1'b1, R, 1'b0, 2);

    // Two lamps lit together
    applyStimulus(1'b1, OFF, 1'b1, 1);
    applyStimulus(1'b1, G, 1'b0, 5);
    applyStimulus(1'b1, R | G, 1'b0, 2);

    // Bad pattern judged in the same cycle as a clear: clear wins, then re-fault
    applyStimulus(1'b1, OFF, 1'b1, 1);
    applyStimulus(1'b1, G, 1'b0, 5);
    applyStimulus(1'b1, R | G, 1'b0, 1);
    applyStimulus(1'b1, R | G, 1'b1, 1);
    applyStimulus(1'b1, R | G, 1'b0, 2);

    // Disable mid-yellow with dark lamps, then a lamp lit while disabled
    applyStimulus(1'b1, OFF, 1'b1, 1);
    applyStimulus(1'b1, G, 1'b0, 4);
    applyStimulus(1'b1, Y, 1'b0, 1);
    applyStimulus(1'b0, OFF, 1'b0, 3);
    applyStimulus(1'b0, Y, 1'b0, 2);

    // Fault while in red, then asynchronous reset between edges
    applyStimulus(1'b0, OFF, 1'b1, 1);
    applyStimulus(1'b1, OFF, 1'b0, 2);
    lightCycle(5, 2, 2);
    applyStimulus(1'b1, R | Y, 1'b0, 2);
    checkOutput("pre_reset_fault", 32'(bus.fault), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, OFF, 1'b0, 2);
    lightCycle(4, 3, 5);
    applyStimulus(1'b1, G, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
